// File: rtl/load_decode_pipe_pkg.sv
// Shared types for the load decoder: LOAD opcode, funct3 encodings, access
// size and the decoded entry carried through the main/skid registers.
package load_decode_pipe_pkg;

  localparam logic [6:0] LOAD_OPCODE = 7'b0000011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_RSV = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  // imm is kept as the raw 12-bit field; sign extension to XLEN is pure wiring
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [11:0] imm12;
    funct3_e     funct3;
    size_e       size;
    logic        uns;
    logic        illegal;
  } load_entry_t;

  function automatic logic funct3_legal(input funct3_e f3, input logic rv64);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      F3_LD, F3_LWU:                       ok = rv64;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_field_decode.sv
// Combinational field extraction and legality check for an I-type load word.
module load_field_decode
  import load_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]  instr,
  output load_entry_t  entry
);

  localparam logic RV64 = (XLEN == 64) ? 1'b1 : 1'b0;

  // field slicing plus opcode/funct3 legality
  always_comb begin
    entry         = '0;
    entry.rs1     = instr[19:15];
    entry.rd      = instr[11:7];
    entry.imm12   = instr[31:20];
    entry.funct3  = funct3_e'(instr[14:12]);
    entry.size    = size_e'(instr[13:12]);
    entry.uns     = instr[14];
    entry.illegal = (instr[6:0] != LOAD_OPCODE) || !funct3_legal(funct3_e'(instr[14:12]), RV64);
  end

endmodule

// File: rtl/load_decode_pipe.sv
// Load-instruction decode stage with a 2-entry (main + skid) buffer so that
// in_ready comes straight from state flops, plus a saturating illegal counter.
module load_decode_pipe
  import load_decode_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_load_control,
  output logic [1:0]       out_size,
  output logic             out_unsigned,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  // encoding is {main_valid, skid_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } pipe_state_e;

  pipe_state_e       state_q, state_d;
  load_entry_t       main_q, main_d;
  load_entry_t       skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  load_entry_t       dec_s;
  logic              accept_s;
  logic              out_fire_s;
  logic              load_main_in_s;
  logic              load_main_skid_s;
  logic              load_skid_s;

  load_field_decode #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .entry (dec_s)
  );

  assign in_ready   = (state_q != ST_SKID);
  assign out_valid  = state_q[1];
  assign accept_s   = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // state and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state: flush wins over everything and empties both slots
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = accept_s ? ST_FULL : ST_EMPTY;
        ST_FULL: begin
          if (accept_s && !out_ready) begin
            state_d = ST_SKID;
          end else if (!accept_s && out_ready) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID:  state_d = out_ready ? ST_FULL : ST_SKID;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // slot load enables per state
  always_comb begin
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: load_main_in_s = accept_s;
        ST_FULL: begin
          load_main_in_s = accept_s & out_ready;
          load_skid_s    = accept_s & ~out_ready;
        end
        ST_SKID:  load_main_skid_s = out_ready;
        default: begin
          load_main_in_s   = 1'b0;
          load_main_skid_s = 1'b0;
          load_skid_s      = 1'b0;
        end
      endcase
    end else begin
      load_main_in_s   = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
    end
  end

  // datapath muxing and saturating illegal counter
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (load_main_in_s) begin
      main_d = dec_s;
    end else if (load_main_skid_s) begin
      main_d = skid_q;
    end else begin
      main_d = main_q;
    end
    if (load_skid_s) begin
      skid_d = dec_s;
    end else begin
      skid_d = skid_q;
    end
    if (out_fire_s && main_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign out_rs1          = main_q.rs1;
  assign out_rd           = main_q.rd;
  assign out_imm          = {{(XLEN-12){main_q.imm12[11]}}, main_q.imm12};
  assign out_load_control = main_q.funct3;
  assign out_size         = main_q.size;
  assign out_unsigned     = main_q.uns;
  assign out_illegal      = main_q.illegal;
  assign illegal_count    = cnt_q;

endmodule

// File: tb/tb_load_decode_pipe.sv
// Scoreboard bench: an XLEN=32 and an XLEN=64 (2-bit counter) instance share
// one stimulus stream; a monitor checks every output handshake against a model.
module tb_load_decode_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, uns32, ill32;
  logic [4:0]  rs1_32, rd32;
  logic [31:0] imm32;
  logic [2:0]  lc32;
  logic [1:0]  size32;
  logic [15:0] cnt32;

  logic        in_ready64, out_valid64, uns64, ill64;
  logic [4:0]  rs1_64, rd64;
  logic [63:0] imm64;
  logic [2:0]  lc64;
  logic [1:0]  size64;
  logic [1:0]  cnt64;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int n_out32 = 0;
  int n_out64 = 0;
  logic [15:0] mcnt32 = 16'h0;
  logic [1:0]  mcnt64 = 2'h0;
  logic [80:0] q32[$];
  logic [80:0] q64[$];
  logic [80:0] obs32, obs64;

  always #5 clk = ~clk;

  load_decode_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready), .out_rs1(rs1_32),
    .out_rd(rd32), .out_imm(imm32), .out_load_control(lc32), .out_size(size32),
    .out_unsigned(uns32), .out_illegal(ill32), .illegal_count(cnt32)
  );

  load_decode_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready), .out_rs1(rs1_64),
    .out_rd(rd64), .out_imm(imm64), .out_load_control(lc64), .out_size(size64),
    .out_unsigned(uns64), .out_illegal(ill64), .illegal_count(cnt64)
  );

  assign obs32 = {rs1_32, rd32, 32'h0, imm32, lc32, size32, uns32, ill32};
  assign obs64 = {rs1_64, rd64, imm64, lc64, size64, uns64, ill64};

  // reference decode: {rs1, rd, imm64, funct3, size, unsigned, illegal}
  function automatic logic [80:0] model(input logic [31:0] w, input bit is64);
    logic [63:0] imm;
    logic [2:0]  f3;
    logic        ill;
    f3  = w[14:12];
    imm = {{52{w[31]}}, w[31:20]};
    if (!is64) imm[63:32] = 32'h0;
    ill = (w[6:0] != 7'b0000011) || (f3 == 3'b111) ||
          (!is64 && ((f3 == 3'b011) || (f3 == 3'b110)));
    return {w[19:15], w[11:7], imm, f3, f3[1:0], f3[2], ill};
  endfunction

  // monitor: pop/compare on output handshakes, push on accepted inputs
  initial begin
    logic [80:0] e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q32.delete(); q64.delete();
        mcnt32 = 16'h0; mcnt64 = 2'h0;
      end else begin
        if (out_valid32 && out_ready) begin
          total++;
          if (q32.size() == 0) begin
            bad++; $display("FAIL out32_extra got=%h want=none", obs32);
          end else begin
            e = q32.pop_front();
            if (obs32 !== e) begin bad++; $display("FAIL out32_entry got=%h want=%h", obs32, e); end
            if (e[0] && mcnt32 != 16'hFFFF) mcnt32 = mcnt32 + 16'd1;
            n_out32++;
          end
        end
        if (out_valid64 && out_ready) begin
          total++;
          if (q64.size() == 0) begin
            bad++; $display("FAIL out64_extra got=%h want=none", obs64);
          end else begin
            e = q64.pop_front();
            if (obs64 !== e) begin bad++; $display("FAIL out64_entry got=%h want=%h", obs64, e); end
            if (e[0] && mcnt64 != 2'b11) mcnt64 = mcnt64 + 2'd1;
            n_out64++;
          end
        end
        if (flush) begin
          q32.delete(); q64.delete();
        end else if (in_valid && in_ready32) begin
          q32.push_back(model(in_instr, 1'b0));
          q64.push_back(model(in_instr, 1'b1));
          acc_cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    int n0;
    bit got;
    n0 = acc_cnt; got = 1'b0;
    in_valid = 1'b1; in_instr = w;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != n0) got = 1'b1;
    end
    in_valid = 1'b0;
    if (!got) begin total++; bad++; $display("FAIL send_timeout instr=%h", w); end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      if (q32.size() == 0 && q64.size() == 0 && !out_valid32 && !out_valid64) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!done) begin bad++; $display("FAIL drain_timeout got=%0d left want=0", q32.size()); end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid32, out_valid64, in_ready32, in_ready64} !== 4'b0011) begin
      bad++; $display("FAIL reset_hs got=%b want=0011", {out_valid32, out_valid64, in_ready32, in_ready64});
    end
    total++;
    if ({cnt32, cnt64, rs1_32, rd32, imm32, lc32, size32, uns32, ill32} !== '0 || imm64 !== 64'h0) begin
      bad++; $display("FAIL reset_fields got cnt=%h imm=%h rs1=%h want=0", cnt32, imm32, rs1_32);
    end
  endtask

  task automatic test_lw();
    out_ready = 1'b1;
    send(32'hFFC12083);
    total++;
    if (!(out_valid32 === 1'b1 && rs1_32 === 5'd2 && rd32 === 5'd1 && imm32 === 32'hFFFF_FFFC &&
          size32 === 2'd2 && uns32 === 1'b0 && ill32 === 1'b0)) begin
      bad++; $display("FAIL lw32 got v=%b rs1=%0d rd=%0d imm=%h sz=%0d u=%b il=%b want 1 2 1 fffffffc 2 0 0",
                      out_valid32, rs1_32, rd32, imm32, size32, uns32, ill32);
    end
    total++;
    if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFC || ill64 !== 1'b0) begin
      bad++; $display("FAIL lw64 got imm=%h il=%b want fffffffffffffffc 0", imm64, ill64);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid32 !== 1'b0) begin bad++; $display("FAIL lw_drain got=%b want=0", out_valid32); end
  endtask

  task automatic test_ld();
    out_ready = 1'b1;
    send(32'h00813183);
    total++;
    if (!(size64 === 2'd3 && ill64 === 1'b0 && imm64 === 64'h8 && rd64 === 5'd3 && rs1_64 === 5'd2)) begin
      bad++; $display("FAIL ld64 got sz=%0d il=%b imm=%h rd=%0d want 3 0 8 3", size64, ill64, imm64, rd64);
    end
    total++;
    if (ill32 !== 1'b1 || size32 !== 2'd3) begin
      bad++; $display("FAIL ld32 got il=%b sz=%0d want 1 3", ill32, size32);
    end
    drain();
  endtask

  task automatic test_funct3();
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send({12'h7F0 + 12'(f), 5'(f + 3), 3'(f), 5'(f + 7), 7'b0000011});
    end
    drain();
    total++;
    if (cnt32 !== mcnt32 || cnt64 !== mcnt64) begin
      bad++; $display("FAIL f3_count got=%0d/%0d want=%0d/%0d", cnt32, cnt64, mcnt32, mcnt64);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [80:0] head;
    n0 = n_out32;
    out_ready = 1'b1;
    send(32'h00412083);
    out_ready = 1'b0;
    send(32'h80012103);
    total++;
    if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
      bad++; $display("FAIL b2b_full got=%b%b want=00", in_ready32, in_ready64);
    end
    head = model(32'h00412083, 1'b0);
    in_valid = 1'b1; in_instr = 32'h7FF1C183;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || obs32 !== head) begin
      bad++; $display("FAIL b2b_stall got r=%b v=%b d=%h want 0 1 %h", in_ready32, out_valid32, obs32, head);
    end
    out_ready = 1'b1;
    send(32'h7FF1C183);
    send(32'h00029203);
    drain();
    total++;
    if (n_out32 - n0 != 4 || n_out64 != n_out32) begin
      bad++; $display("FAIL b2b_count got=%0d want=4", n_out32 - n0);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    send(32'h00007003);
    send(32'h00000013);
    drain();
    total++;
    if (cnt32 !== 16'd2 || cnt64 !== 2'd2) begin
      bad++; $display("FAIL illegal_two got=%0d/%0d want=2/2", cnt32, cnt64);
    end
    for (int i = 0; i < 3; i++) send(32'h00107013);
    drain();
    total++;
    if (cnt32 !== 16'd5 || cnt64 !== 2'd3) begin
      bad++; $display("FAIL illegal_sat got=%0d/%0d want=5/3", cnt32, cnt64);
    end
  endtask

  task automatic test_flush();
    int n0;
    out_ready = 1'b0;
    send(32'h00002003);
    send(32'h00004083);
    total++;
    if (in_ready32 !== 1'b0) begin bad++; $display("FAIL flush_pre got=%b want=0", in_ready32); end
    n0 = n_out32;
    in_valid = 1'b1; in_instr = 32'hFFF03303; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid32, out_valid64, in_ready32, in_ready64} !== 4'b0011) begin
      bad++; $display("FAIL flush_skid got=%b want=0011", {out_valid32, out_valid64, in_ready32, in_ready64});
    end
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    total++;
    if (out_valid32 !== 1'b0 || n_out32 != n0) begin
      bad++; $display("FAIL flush_drop got v=%b outs=%0d want 0 %0d", out_valid32, n_out32, n0);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send(32'h00000013);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00002083);
    send(32'h00001103);
    total++;
    if (cnt32 !== mcnt32 || out_valid32 !== 1'b1) begin
      bad++; $display("FAIL arst_pre got cnt=%0d v=%b want %0d 1", cnt32, out_valid32, mcnt32);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({out_valid32, out_valid64, in_ready32, in_ready64} !== 4'b0011 || cnt32 !== 16'd0 || cnt64 !== 2'd0) begin
      bad++; $display("FAIL arst got v=%b%b r=%b%b cnt=%0d want 00 11 0",
                      out_valid32, out_valid64, in_ready32, in_ready64, cnt32);
    end
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid32 !== 1'b0) begin bad++; $display("FAIL arst_post got=%b want=0", out_valid32); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_ld();
    test_funct3();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
